// File: rtl/mmio_bus.sv
// mmio_bus: word RAM, LED register, free-running cycle counter, and a
// FIFO-fed 8N1 UART transmitter, all behind one combinational MMIO port.
//
// Ports:
//   clk          clock, all state updates on posedge
//   rst          synchronous active-high reset
//   mem_addr     byte address from core (bits [1:0] ignored)
//   mem_wr_data  store data from core
//   mem_wr_ena   store strobe, committed at posedge
//   mem_rd_data  combinational read data for mem_addr
//   leds         LED register contents
//   uart_tx      serial transmit line, idle high
module mmio_bus #(
    parameter int RAM_WORDS    = 256,
    parameter int CLKS_PER_BIT = 4,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wr_data,
    input  logic        mem_wr_ena,
    output logic [31:0] mem_rd_data,
    output logic [7:0]  leds,
    output logic        uart_tx
);

    localparam int AW = $clog2(RAM_WORDS);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int DW = $clog2(CLKS_PER_BIT);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLKS_PER_BIT - 1);

    localparam logic [29:0] WORD_LED = 30'h3FFF_C000;
    localparam logic [29:0] WORD_CYC = 30'h3FFF_C001;
    localparam logic [29:0] WORD_TX  = 30'h3FFF_C002;
    localparam logic [29:0] WORD_ST  = 30'h3FFF_C003;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    // Address decode
    logic [29:0] w_word;
    logic        w_sel_ram;
    logic        w_sel_led;
    logic        w_sel_cyc;
    logic        w_sel_tx;
    logic        w_sel_st;
    logic        w_we;
    logic        w_unused;

    assign w_word    = mem_addr[31:2];
    assign w_sel_ram = (mem_addr[31:AW+2] == '0);
    assign w_sel_led = (w_word == WORD_LED);
    assign w_sel_cyc = (w_word == WORD_CYC);
    assign w_sel_tx  = (w_word == WORD_TX);
    assign w_sel_st  = (w_word == WORD_ST);
    // Stores are suppressed while reset is held.
    assign w_we      = mem_wr_ena && !rst;
    assign w_unused  = &{1'b0, mem_addr[1:0]};

    // Data RAM, not affected by reset
    logic [31:0] r_ram [RAM_WORDS];

    always_ff @(posedge clk) begin
        if (w_we && w_sel_ram) begin
            r_ram[mem_addr[AW+1:2]] <= mem_wr_data;
        end
    end

    // LED, cycle counter, sticky overflow
    logic [7:0]  r_led;
    logic [31:0] r_cycles;
    logic        r_ovf;

    // TX FIFO with one extra pointer bit to tell full from empty
    logic [7:0]  r_fifo [FIFO_DEPTH];
    logic [PW:0] r_wptr;
    logic [PW:0] r_rptr;
    logic        w_empty;
    logic        w_full;
    logic        w_push;
    logic        w_drop;
    logic        w_pop;
    logic [7:0]  w_head;

    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[PW] != r_rptr[PW]) &&
                     (r_wptr[PW-1:0] == r_rptr[PW-1:0]);
    // Fullness is judged at the edge, so a simultaneous pop does not rescue it.
    assign w_push  = w_we && w_sel_tx && !w_full;
    assign w_drop  = w_we && w_sel_tx && w_full;
    assign w_head  = r_fifo[r_rptr[PW-1:0]];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wptr[PW-1:0]] <= mem_wr_data[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_led    <= '0;
            r_cycles <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            if (w_we && w_sel_led) begin
                r_led <= mem_wr_data[7:0];
            end
            r_cycles <= r_cycles + 32'd1;
            // A drop in the same cycle wins over the clear.
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (w_we && w_sel_st) begin
                r_ovf <= 1'b0;
            end
        end
    end

    // UART shifter
    state_t        r_state;
    state_t        w_state_nx;
    logic [DW-1:0] r_div;
    logic [DW-1:0] w_div_nx;
    logic [2:0]    r_bit;
    logic [2:0]    w_bit_nx;
    logic [7:0]    r_shift;
    logic [7:0]    w_shift_nx;
    logic          w_div_end;
    logic          w_tx;
    logic          w_busy;

    assign w_div_end = (r_div == DIV_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_div   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
        end else begin
            r_state <= w_state_nx;
            r_div   <= w_div_nx;
            r_bit   <= w_bit_nx;
            r_shift <= w_shift_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_div_nx   = r_div;
        w_bit_nx   = r_bit;
        w_shift_nx = r_shift;
        w_pop      = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop      = 1'b1;
                    w_shift_nx = w_head;
                    w_div_nx   = '0;
                    w_state_nx = S_START;
                end
            end
            S_START: begin
                w_div_nx = r_div + 1'b1;
                if (w_div_end) begin
                    w_div_nx   = '0;
                    w_bit_nx   = '0;
                    w_state_nx = S_DATA;
                end
            end
            S_DATA: begin
                w_div_nx = r_div + 1'b1;
                if (w_div_end) begin
                    w_div_nx   = '0;
                    w_shift_nx = {1'b0, r_shift[7:1]};
                    w_bit_nx   = r_bit + 3'd1;
                    if (r_bit == 3'd7) begin
                        w_state_nx = S_STOP;
                    end
                end
            end
            S_STOP: begin
                w_div_nx = r_div + 1'b1;
                if (w_div_end) begin
                    w_div_nx = '0;
                    // Chain straight into the next frame when data waits.
                    if (!w_empty) begin
                        w_pop      = 1'b1;
                        w_shift_nx = w_head;
                        w_state_nx = S_START;
                    end else begin
                        w_state_nx = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    always_comb begin
        w_tx = 1'b1;
        unique case (r_state)
            S_IDLE:  w_tx = 1'b1;
            S_START: w_tx = 1'b0;
            S_DATA:  w_tx = r_shift[0];
            S_STOP:  w_tx = 1'b1;
            default: w_tx = 1'b1;
        endcase
    end

    assign w_busy = !w_empty || (r_state != S_IDLE);

    // Read mux
    always_comb begin
        mem_rd_data = '0;
        if (w_sel_ram) begin
            mem_rd_data = r_ram[mem_addr[AW+1:2]];
        end else if (w_sel_led) begin
            mem_rd_data = {24'b0, r_led};
        end else if (w_sel_cyc) begin
            mem_rd_data = r_cycles;
        end else if (w_sel_st) begin
            mem_rd_data = {29'b0, r_ovf, w_busy, w_full};
        end
    end

    assign leds    = r_led;
    assign uart_tx = w_tx;

endmodule

// File: tb/tb_mmio_bus.sv
// tb_mmio_bus: table-driven MMIO checks plus a UART receiver scoreboard
// that compares every decoded frame against the bytes queued by stores.
module tb_mmio_bus;

    localparam int RAM_WORDS    = 256;
    localparam int CLKS_PER_BIT = 4;
    localparam int FIFO_DEPTH   = 4;

    localparam logic [31:0] A_LED = 32'hFFFF_0000;
    localparam logic [31:0] A_CYC = 32'hFFFF_0004;
    localparam logic [31:0] A_TX  = 32'hFFFF_0008;
    localparam logic [31:0] A_ST  = 32'hFFFF_000C;

    logic        clk;
    logic        rst;
    logic [31:0] mem_addr;
    logic [31:0] mem_wr_data;
    logic        mem_wr_ena;
    logic [31:0] mem_rd_data;
    logic [7:0]  leds;
    logic        uart_tx;

    mmio_bus #(
        .RAM_WORDS   (RAM_WORDS),
        .CLKS_PER_BIT(CLKS_PER_BIT),
        .FIFO_DEPTH  (FIFO_DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .mem_addr   (mem_addr),
        .mem_wr_data(mem_wr_data),
        .mem_wr_ena (mem_wr_ena),
        .mem_rd_data(mem_rd_data),
        .leds       (leds),
        .uart_tx    (uart_tx)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_fail   = 0;
    int frames   = 0;
    logic [7:0] exp_q[$];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        mem_addr    = a;
        mem_wr_data = d;
        mem_wr_ena  = 1'b1;
        @(posedge clk);
        #1;
        mem_wr_ena  = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] v);
        mem_addr = a;
        #1;
        v = mem_rd_data;
    endtask

    task automatic wait_frames(input int target, input int budget);
        for (int i = 0; i < budget && frames < target; i++) begin
            @(posedge clk);
        end
        #1;
        chk("frame_count", frames, target);
    endtask

    // Independent 8N1 receiver sampling every cycle on the falling edge
    int         m_ph  = 0;
    int         m_cnt = 0;
    int         m_bit = 0;
    logic [7:0] m_byte;
    logic [7:0] m_exp;

    always @(negedge clk) begin
        if (rst) begin
            m_ph = 0;
        end else begin
            case (m_ph)
                0: begin
                    if (uart_tx === 1'b0) begin
                        m_ph  = 1;
                        m_cnt = 1;
                    end
                end
                1: begin
                    if (uart_tx !== 1'b0)
                        chk("start_bit", {31'b0, uart_tx}, 32'd0);
                    m_cnt++;
                    if (m_cnt == CLKS_PER_BIT) begin
                        m_ph  = 2;
                        m_cnt = 0;
                        m_bit = 0;
                    end
                end
                2: begin
                    if (m_cnt == 0)
                        m_byte[m_bit] = uart_tx;
                    else if (uart_tx !== m_byte[m_bit])
                        chk("data_bit_hold", {31'b0, uart_tx},
                            {31'b0, m_byte[m_bit]});
                    m_cnt++;
                    if (m_cnt == CLKS_PER_BIT) begin
                        m_cnt = 0;
                        m_bit++;
                        if (m_bit == 8) m_ph = 3;
                    end
                end
                default: begin
                    if (uart_tx !== 1'b1)
                        chk("stop_bit", {31'b0, uart_tx}, 32'd1);
                    m_cnt++;
                    if (m_cnt == CLKS_PER_BIT) begin
                        m_ph = 0;
                        frames++;
                        if (exp_q.size() == 0) begin
                            chk("unexpected_frame", {24'b0, m_byte}, 32'hX);
                        end else begin
                            m_exp = exp_q.pop_front();
                            chk("frame_byte", {24'b0, m_byte}, {24'b0, m_exp});
                        end
                    end
                end
            endcase
        end
    end

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] data;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] v;
    logic [31:0] c0;
    int          f0;

    initial begin
        rst         = 1'b1;
        mem_addr    = '0;
        mem_wr_data = '0;
        mem_wr_ena  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_uart_tx", {31'b0, uart_tx}, 32'd1);
        chk("rst_leds", {24'b0, leds}, 32'd0);
        rd(A_CYC, v);
        chk("rst_cycles", v, 32'd0);
        rd(A_ST, v);
        chk("rst_status", v, 32'd0);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rd(A_CYC, v);
        chk("cycles_after_rst", v, 32'd3);

        vecs.push_back('{1'b1, 32'h0000_0010, 32'hDEAD_BEEF});
        vecs.push_back('{1'b0, 32'h0000_0010, 32'hDEAD_BEEF});
        vecs.push_back('{1'b0, 32'h0000_0013, 32'hDEAD_BEEF});
        vecs.push_back('{1'b1, 32'h0000_0000, 32'h1111_2222});
        vecs.push_back('{1'b1, 32'h8000_0000, 32'h0000_AAAA});
        vecs.push_back('{1'b1, RAM_WORDS * 4, 32'h0000_BBBB});
        vecs.push_back('{1'b0, 32'h0000_0000, 32'h1111_2222});
        vecs.push_back('{1'b0, 32'h8000_0000, 32'h0000_0000});
        vecs.push_back('{1'b0, RAM_WORDS * 4, 32'h0000_0000});
        vecs.push_back('{1'b1, A_LED, 32'h0000_01A5});
        vecs.push_back('{1'b0, A_LED, 32'h0000_00A5});
        vecs.push_back('{1'b0, A_TX, 32'h0000_0000});
        vecs.push_back('{1'b1, 32'hFFFF_0010, 32'h1234_5678});
        vecs.push_back('{1'b0, 32'hFFFF_0010, 32'h0000_0000});
        vecs.push_back('{1'b1, RAM_WORDS * 4 - 4, 32'hCAFE_F00D});
        vecs.push_back('{1'b0, RAM_WORDS * 4 - 4, 32'hCAFE_F00D});
        vecs.push_back('{1'b0, A_ST, 32'h0000_0000});

        foreach (vecs[i]) begin
            if (vecs[i].we) begin
                wr(vecs[i].addr, vecs[i].data);
            end else begin
                rd(vecs[i].addr, v);
                chk($sformatf("vec%0d_rd_%h", i, vecs[i].addr), v, vecs[i].data);
            end
        end
        chk("leds_pins", {24'b0, leds}, 32'h0000_00A5);

        rd(A_CYC, c0);
        wr(A_CYC, 32'h0);
        repeat (4) @(posedge clk);
        #1;
        rd(A_CYC, v);
        chk("cycles_delta_ro", v - c0, 32'd5);

        // Single frame, exact start latency and busy duration
        f0 = frames;
        wr(A_TX, 32'h0000_0155);
        exp_q.push_back(8'h55);
        chk("tx_idle_at_push", {31'b0, uart_tx}, 32'd1);
        rd(A_ST, v);
        chk("busy_after_push", v, 32'h2);
        @(posedge clk);
        #1;
        chk("start_after_pop", {31'b0, uart_tx}, 32'd0);
        repeat (39) @(posedge clk);
        #1;
        rd(A_ST, v);
        chk("busy_last_stop", v, 32'h2);
        @(posedge clk);
        #1;
        rd(A_ST, v);
        chk("idle_after_frame", v, 32'h0);
        chk("one_frame", frames, f0 + 1);

        // Burst into a 4-deep FIFO: five accepted, sixth dropped
        f0 = frames;
        for (int i = 0; i < 6; i++) begin
            wr(A_TX, 32'h30 + i);
            if (i < 5) exp_q.push_back(8'(8'h30 + i));
        end
        rd(A_ST, v);
        chk("status_overflow", v, 32'h7);
        wr(A_ST, 32'h0);
        rd(A_ST, v);
        chk("status_ovf_clear", v, 32'h3);
        wait_frames(f0 + 5, 5 * 10 * CLKS_PER_BIT + 40);
        rd(A_ST, v);
        chk("status_drained", v, 32'h0);
        chk("queue_drained", exp_q.size(), 32'd0);

        // Reset mid-frame; stores during reset must be ignored
        wr(32'h0000_0020, 32'h0000_0001);
        wr(A_TX, 32'h0000_00A3);
        exp_q.push_back(8'hA3);
        repeat (12) @(posedge clk);
        #1;
        rst = 1'b1;
        exp_q.delete();
        mem_addr    = 32'h0000_0020;
        mem_wr_data = 32'h0000_0077;
        mem_wr_ena  = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_abort_tx", {31'b0, uart_tx}, 32'd1);
        mem_addr = A_LED;
        @(posedge clk);
        #1;
        mem_wr_ena = 1'b0;
        rst = 1'b0;
        f0 = frames;
        repeat (3) @(posedge clk);
        #1;
        rd(A_CYC, v);
        chk("cycles_restart", v, 32'd3);
        rd(A_ST, v);
        chk("status_after_rst", v, 32'h0);
        chk("leds_after_rst", {24'b0, leds}, 32'd0);
        rd(32'h0000_0020, v);
        chk("ram_wr_in_rst", v, 32'h0000_0001);
        rd(32'h0000_0010, v);
        chk("ram_kept", v, 32'hDEAD_BEEF);
        repeat (60) @(posedge clk);
        #1;
        chk("no_frame_after_rst", frames, f0);
        chk("tx_idle_after_rst", {31'b0, uart_tx}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule
